// File: rtl/config_spi_controller.sv
// Replays the register list held in the 256-byte config memory as 16-bit SPI
// frames to the DAC or ADC board; read frames return a byte on the readback port.
module config_spi_controller #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] config_read_addr,
  input  logic [7:0] config_read_data,
  output logic       spi_dac_cs,
  output logic       spi_dac_mclk,
  output logic       spi_dac_mdi,
  input  logic       spi_dac_mdo,
  output logic       spi_adc_cs,
  output logic       spi_adc_mclk,
  output logic       spi_adc_mdi,
  input  logic       spi_adc_mdo,
  output logic       busy,
  output logic       done,
  output logic [6:0] entry_count,
  output logic       readback_valid,
  output logic [6:0] readback_addr,
  output logic [7:0] readback_data
);
  localparam int CW = $clog2(2 * CLK_DIV) + 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(2 * CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH_CTRL, S_FETCH_REG, S_FETCH_DATA,
    S_CS_SETUP, S_SHIFT, S_CS_HOLD, S_GAP, S_FINISH
  } state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          r_high;
  logic [3:0]    r_bit;
  logic [5:0]    r_idx;
  logic          r_tgt, r_rd;
  logic [6:0]    r_reg;
  logic [15:0]   r_shift;
  logic [7:0]    r_rx;
  logic [7:0]    r_addr;
  logic          r_busy, r_done;
  logic [6:0]    r_count;
  logic          r_rb_valid;
  logic [6:0]    r_rb_addr;
  logic [7:0]    r_rb_data;
  logic          w_start_ok, w_div_last, w_gap_last, w_bit_end, w_rise;
  logic          w_cs_act, w_mclk, w_mdi, w_mdo;

  // busy stays high through the done cycle, so a start coincident with done is dropped
  assign w_start_ok = start && (r_state == S_IDLE) && !r_busy;
  assign w_div_last = (r_cnt == DIV_LAST);
  assign w_gap_last = (r_cnt == GAP_LAST);
  assign w_bit_end  = (r_state == S_SHIFT) && r_high && w_div_last;
  assign w_rise     = (r_state == S_SHIFT) && r_high && (r_cnt == '0);
  assign w_mdo      = r_tgt ? spi_adc_mdo : spi_dac_mdo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (w_start_ok) w_next = S_FETCH_CTRL;
      S_FETCH_CTRL: w_next = config_read_data[7] ? S_FETCH_REG : S_FINISH;
      S_FETCH_REG:  w_next = S_FETCH_DATA;
      S_FETCH_DATA: w_next = S_CS_SETUP;
      S_CS_SETUP:   if (w_div_last) w_next = S_SHIFT;
      S_SHIFT:      if (w_bit_end && (r_bit == 4'd15)) w_next = S_CS_HOLD;
      S_CS_HOLD:    if (w_div_last) w_next = S_GAP;
      S_GAP:        if (w_gap_last) w_next = (r_idx == 6'd63) ? S_FINISH : S_FETCH_CTRL;
      S_FINISH:     w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_high     <= 1'b0;
      r_bit      <= '0;
      r_idx      <= '0;
      r_tgt      <= 1'b0;
      r_rd       <= 1'b0;
      r_reg      <= '0;
      r_shift    <= '0;
      r_rx       <= '0;
      r_addr     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_count    <= '0;
      r_rb_valid <= 1'b0;
      r_rb_addr  <= '0;
      r_rb_data  <= '0;
    end else begin
      r_done     <= (r_state == S_FINISH);
      r_rb_valid <= 1'b0;
      if (r_done) r_busy <= 1'b0;
      // one counter times every phase; in SHIFT it restarts at each half-bit
      if ((w_next != r_state) || ((r_state == S_SHIFT) && w_div_last)) r_cnt <= '0;
      else                                                              r_cnt <= r_cnt + 1'b1;
      case (r_state)
        S_IDLE: if (w_start_ok) begin
          r_busy  <= 1'b1;
          r_count <= '0;
          r_idx   <= '0;
          r_addr  <= '0;
        end
        S_FETCH_CTRL: begin
          r_tgt <= config_read_data[6];
          r_rd  <= config_read_data[5];
          if (config_read_data[7]) r_addr <= r_addr + 8'd1;
        end
        S_FETCH_REG: begin
          r_reg  <= config_read_data[6:0];
          r_addr <= r_addr + 8'd1;
        end
        S_FETCH_DATA: r_shift <= {r_rd, r_reg, config_read_data};
        S_SHIFT: begin
          if (w_rise) r_rx <= {r_rx[6:0], w_mdo};
          if (w_bit_end) begin
            r_high  <= 1'b0;
            r_shift <= {r_shift[14:0], 1'b0};
            r_bit   <= r_bit + 4'd1;
          end else if (w_div_last) begin
            r_high <= 1'b1;
          end
        end
        S_CS_HOLD: if (w_div_last) begin
          r_count <= r_count + 7'd1;
          if (r_rd) begin
            r_rb_valid <= 1'b1;
            r_rb_addr  <= r_reg;
            r_rb_data  <= r_rx;
          end
        end
        S_GAP: if (w_gap_last && (r_idx != 6'd63)) begin
          r_idx  <= r_idx + 6'd1;
          r_addr <= {r_idx + 6'd1, 2'b00};
        end
        default: ;
      endcase
    end
  end

  // SPI lines decode straight from state so reset forces them idle immediately
  assign w_cs_act = (r_state == S_CS_SETUP) || (r_state == S_SHIFT) || (r_state == S_CS_HOLD);
  assign w_mclk   = (r_state == S_SHIFT) && r_high;
  assign w_mdi    = ((r_state == S_CS_SETUP) || (r_state == S_SHIFT)) && r_shift[15];

  assign spi_dac_cs   = !(w_cs_act && !r_tgt);
  assign spi_dac_mclk = w_mclk && !r_tgt;
  assign spi_dac_mdi  = w_mdi && !r_tgt;
  assign spi_adc_cs   = !(w_cs_act && r_tgt);
  assign spi_adc_mclk = w_mclk && r_tgt;
  assign spi_adc_mdi  = w_mdi && r_tgt;

  assign config_read_addr = r_addr;
  assign busy             = r_busy;
  assign done             = r_done;
  assign entry_count      = r_count;
  assign readback_valid   = r_rb_valid;
  assign readback_addr    = r_rb_addr;
  assign readback_data    = r_rb_data;
endmodule

// File: tb/tb_config_spi_controller.sv
// Bench for config_spi_controller: random and directed register lists checked
// against a frame-level model of the list plus a run-length timing formula.
module tb_config_spi_controller;
  localparam int D = 4;

  logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0] config_read_addr, config_read_data;
  logic       spi_dac_cs, spi_dac_mclk, spi_dac_mdi, spi_dac_mdo = 1'b0;
  logic       spi_adc_cs, spi_adc_mclk, spi_adc_mdi, spi_adc_mdo = 1'b0;
  logic       busy, done, readback_valid;
  logic [6:0] entry_count, readback_addr;
  logic [7:0] readback_data;
  logic [7:0] mem [256];

  config_spi_controller #(.CLK_DIV(D)) dut (
    .clk(clk), .reset(reset), .start(start),
    .config_read_addr(config_read_addr), .config_read_data(config_read_data),
    .spi_dac_cs(spi_dac_cs), .spi_dac_mclk(spi_dac_mclk), .spi_dac_mdi(spi_dac_mdi), .spi_dac_mdo(spi_dac_mdo),
    .spi_adc_cs(spi_adc_cs), .spi_adc_mclk(spi_adc_mclk), .spi_adc_mdi(spi_adc_mdi), .spi_adc_mdo(spi_adc_mdo),
    .busy(busy), .done(done), .entry_count(entry_count),
    .readback_valid(readback_valid), .readback_addr(readback_addr), .readback_data(readback_data)
  );

  assign config_read_data = mem[config_read_addr];
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        tgt;
    logic        rd;
    logic [6:0]  addr;
    logic [15:0] word;
    logic [7:0]  resp;
  } frm_t;
  frm_t        exp_q[$];
  logic [14:0] rb_q[$];

  int checks = 0, errors = 0;
  bit run_on = 0, fix_en = 0, in_frm = 0, f_prev_mc = 0;
  logic [7:0] fix_resp = 8'h00;
  int t_start = 0, t_done = 0, exp_n = 0;
  int dn_cnt = 0, dn_cyc = 0, frm_cnt = 0, rb_cnt = 0;
  int f_tgt = 0, f_low = 0, f_rises = 0, last_tgt = 0, last_low = 0;
  logic [15:0] f_word = '0, f_mdo_w = '0, last_word = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle compare: port idling, frame capture, readback, busy/done timing.
  // It also plays the converter, shifting the frame's response byte out on mdo.
  always @(negedge clk) begin
    logic [1:0] cs, mc, md;
    frm_t f;
    cs = {spi_adc_cs, spi_dac_cs};
    mc = {spi_adc_mclk, spi_dac_mclk};
    md = {spi_adc_mdi, spi_dac_mdi};
    if (reset) begin
      in_frm = 0;
      spi_dac_mdo = 1'b0;
      spi_adc_mdo = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++)
        if (cs[p]) check("idle_port_static", {30'd0, mc[p], md[p]}, 0);
      check("both_cs_low", (cs == 2'b00), 0);
      if (!in_frm && cs != 2'b11) begin
        in_frm = 1; f_tgt = cs[0] ? 1 : 0; f_low = 0; f_rises = 0; f_word = '0; f_prev_mc = 0;
        f_mdo_w = {8'($urandom), (exp_q.size() > 0) ? exp_q[0].resp : 8'h00};
      end
      if (in_frm && !cs[f_tgt]) begin
        if (!mc[f_tgt] && f_rises < 16) begin
          if (f_tgt == 0) spi_dac_mdo = f_mdo_w[15 - f_rises];
          else            spi_adc_mdo = f_mdo_w[15 - f_rises];
        end
        f_low++;
        if (mc[f_tgt] && !f_prev_mc) begin
          f_word = {f_word[14:0], md[f_tgt]};
          f_rises++;
        end
        f_prev_mc = mc[f_tgt];
      end else if (in_frm) begin
        in_frm = 0; frm_cnt++;
        last_word = f_word; last_tgt = f_tgt; last_low = f_low;
        if (exp_q.size() == 0) check("frame_unexpected", 1, 0);
        else begin
          f = exp_q.pop_front();
          check("frame_target", f_tgt, {31'd0, f.tgt});
          check("frame_word", {16'd0, f_word}, {16'd0, f.word});
          check("frame_cs_low", f_low, 34 * D);
          check("frame_rises", f_rises, 16);
        end
      end
      if (readback_valid) begin
        rb_cnt++;
        if (rb_q.size() == 0) check("readback_unexpected", 1, 0);
        else check("readback", {17'd0, readback_addr, readback_data}, {17'd0, rb_q.pop_front()});
      end
      check("busy", busy, run_on && cyc > t_start && cyc <= t_done);
      check("done", done, run_on && cyc == t_done);
      if (done) begin
        dn_cnt++; dn_cyc = cyc;
        check("entry_count_at_done", entry_count, exp_n);
      end
      if (busy) check("reserved_byte_read", (config_read_addr[1:0] == 2'd3), 0);
    end
  end

  task automatic launch();
    frm_t f;
    exp_n = 0;
    while (exp_n < 64 && mem[4 * exp_n][7]) exp_n++;
    exp_q.delete(); rb_q.delete();
    for (int k = 0; k < exp_n; k++) begin
      f.tgt  = mem[4 * k][6];
      f.rd   = mem[4 * k][5];
      f.addr = mem[4 * k + 1][6:0];
      f.word = {f.rd, f.addr, mem[4 * k + 2]};
      f.resp = fix_en ? fix_resp : 8'($urandom);
      exp_q.push_back(f);
      if (f.rd) rb_q.push_back({f.addr, f.resp});
    end
    dn_cnt = 0; frm_cnt = 0; rb_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; t_start = cyc;
    // every executed entry costs 3 fetches + 34*D cs-low + 2*D gap cycles
    t_done = (exp_n == 64) ? t_start + 2 + 64 * (3 + 36 * D) : t_start + 3 + exp_n * (3 + 36 * D);
    run_on = 1;
    @(posedge clk); #1;
    start = 1'b0;
    check("addr_at_T1", config_read_addr, 0);
  endtask

  task automatic finish_run();
    while (cyc <= t_done + 2) begin @(posedge clk); #1; end
    run_on = 0;
    check("done_once", dn_cnt, 1);
    check("frames_missing", exp_q.size(), 0);
    check("readbacks_missing", rb_q.size(), 0);
    check("entry_count_hold", entry_count, exp_n);
    check("addr_end", config_read_addr, (exp_n == 64) ? 8'hFE : 8'(4 * exp_n));
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    foreach (mem[i]) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dac_cs", spi_dac_cs, 1);
    check("rst_adc_cs", spi_adc_cs, 1);
    check("rst_busy", busy, 0);
    check("rst_addr", config_read_addr, 0);
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("idle_no_done", dn_cnt, 0);
    check("idle_addr", config_read_addr, 0);

    // single DAC write
    mem[0] = 8'h80; mem[1] = 8'h12; mem[2] = 8'hA5; mem[4] = 8'h00;
    launch(); finish_run();
    check("dac_word", {16'd0, last_word}, 32'h12A5);
    check("dac_target", last_tgt, 0);
    check("dac_cs_low", last_low, 136);
    check("dac_frames", frm_cnt, 1);
    check("dac_entry_count", entry_count, 1);

    // single ADC read returning 0x3C
    mem[0] = 8'hE0; mem[1] = 8'h05; mem[2] = 8'h00; mem[4] = 8'h00;
    fix_en = 1; fix_resp = 8'h3C;
    launch(); finish_run();
    fix_en = 0;
    check("adc_word", {16'd0, last_word}, 32'h8500);
    check("adc_target", last_tgt, 1);
    check("adc_rb_count", rb_cnt, 1);
    check("adc_rb_addr", readback_addr, 7'h05);
    check("adc_rb_data", readback_data, 8'h3C);

    // empty list; a start coincident with done must be ignored
    mem[0] = 8'h00;
    launch();
    while (cyc != t_done) begin @(posedge clk); #1; end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    finish_run();
    check("empty_done_latency", dn_cyc - t_start, 3);
    check("empty_frames", frm_cnt, 0);
    check("empty_entry_count", entry_count, 0);
    repeat (10) @(posedge clk);
    #1 check("empty_stays_idle", busy, 0);

    // full table, alternating targets, starts during the run ignored
    for (int k = 0; k < 64; k++) begin
      mem[4 * k]     = 8'h80 | ((k % 2 == 1) ? 8'h40 : 8'h00) | 8'($urandom_range(0, 31));
      mem[4 * k + 1] = 8'($urandom);
      mem[4 * k + 2] = 8'($urandom);
      mem[4 * k + 3] = 8'($urandom);
    end
    launch();
    repeat (600) @(posedge clk);
    pulse_start();
    repeat (3000) @(posedge clk);
    pulse_start();
    finish_run();
    check("full_frames", frm_cnt, 64);
    check("full_entry_count", entry_count, 64);
    check("full_addr_end", config_read_addr, 8'hFE);

    // reset in the middle of a read frame, then replay from entry 0
    mem[0] = 8'hA0; mem[1] = 8'h33; mem[2] = 8'h5A;
    mem[4] = 8'hE0; mem[5] = 8'h44; mem[6] = 8'h00;
    mem[8] = 8'hC0; mem[9] = 8'h7F; mem[10] = 8'hFF;
    mem[12] = 8'h00;
    launch(); finish_run();
    launch();
    for (int i = 0; i < 2000 && !(in_frm && f_rises == 9); i++) begin @(posedge clk); #1; end
    check("reached_bit9", f_rises, 9);
    #1 reset = 1'b1; run_on = 0;
    #1;
    check("midrst_dac_cs", spi_dac_cs, 1);
    check("midrst_dac_mclk", spi_dac_mclk, 0);
    check("midrst_adc_cs", spi_adc_cs, 1);
    check("midrst_adc_mclk", spi_adc_mclk, 0);
    check("midrst_busy", busy, 0);
    check("midrst_count", entry_count, 0);
    check("midrst_rb_data", readback_data, 0);
    check("midrst_addr", config_read_addr, 0);
    exp_q.delete(); rb_q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    launch(); finish_run();
    check("replay_frames", frm_cnt, 3);

    // random lists of random length
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(0, 6);
      foreach (mem[i]) mem[i] = 8'($urandom);
      for (int k = 0; k < n; k++) mem[4 * k] = mem[4 * k] | 8'h80;
      mem[4 * n] = mem[4 * n] & 8'h7F;
      launch(); finish_run();
      check("rand_frames", frm_cnt, n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/config_spi_controller.md
# config_spi_controller

Configuration controller that reads the register list held in the 256-byte configuration memory (written by the FX2 interface) and replays it as 16-bit SPI register transactions to the DAC or ADC converter board. It is the reader/consumer end of the config memory: the FX2 interface writes entries, this block fetches them through the asynchronous read port and serializes them onto the isolated SPI lines. Read transactions capture returned data and present it on a readback port.

## Interface
- CLK_DIV, 4: mclk half-period in clk cycles (>= 2)
- clk  in  1  system clock (100-150 MHz)
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse; begin a run at entry 0; ignored while busy
- config_read_addr  out  8  config memory read address
- config_read_data  in  8  config memory async read data (valid same cycle)
- spi_dac_cs / spi_dac_mclk / spi_dac_mdi  out  1 each  DAC SPI chip select (active low), clock, data
- spi_dac_mdo  in  1  DAC SPI return data
- spi_adc_cs / spi_adc_mclk / spi_adc_mdi  out  1 each  ADC SPI, same meaning
- spi_adc_mdo  in  1  ADC SPI return data
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of run
- entry_count  out  7  entries executed in current/last run (0-64)
- readback_valid  out  1  one-cycle pulse when a read frame completes
- readback_addr  out  7  register address of the read
- readback_data  out  8  byte captured from mdo

## Operation
- Entry n (0-63) occupies bytes 4n..4n+3: ctrl, reg, data, reserved (never read).
- ctrl bit7 = valid (0 terminates list), bit6 = target (0 DAC, 1 ADC), bit5 = read (1) / write (0); bits 4:0 ignored.
- Frame, MSB first: bit15 = read flag, bits14:8 = reg[6:0], bits7:0 = data (reads send data byte as given; mdi content ignored by converter). reg bit7 ignored.
- States: IDLE -> FETCH_CTRL -> (ctrl valid ? FETCH_REG : FINISH) -> FETCH_DATA -> CS_SETUP -> SHIFT -> CS_HOLD -> GAP -> next entry FETCH_CTRL, or FINISH after entry 63 -> IDLE.
- FETCH_* each take one cycle: config_read_addr = 4n+k, config_read_data registered at end of that cycle.
- Only the selected target's cs/mclk/mdi toggle; the other port stays cs=1, mclk=0, mdi=0.
- SPI mode 0: mclk idles low; mdi changes at start of each low phase; mdo sampled in the clk cycle mclk rises; 16 low/high pairs.
- Read frames: mdo samples of bits 7..0 shifted into readback_data; readback_addr = reg[6:0]; readback_valid pulses on CS_HOLD exit. Write frames never touch readback outputs.
- entry_count cleared on accepted start, incremented on each CS_HOLD exit; holds after run.
- Reset (any time, incl. mid-frame): both cs=1, mclk=0, mdi=0, busy=0, done=0, readback_valid=0, readback_data=0, readback_addr=0, entry_count=0, config_read_addr=0, state IDLE. No partial frame resumes.

## Timing
- start at cycle T -> busy=1 at T+1, config_read_addr=0 at T+1.
- CS_SETUP: cs low for CLK_DIV cycles with mclk low and mdi = bit15.
- SHIFT: 32*CLK_DIV cycles; each bit = CLK_DIV low + CLK_DIV high.
- CS_HOLD: mclk low, cs low, CLK_DIV cycles; then cs high.
- GAP: cs high for 2*CLK_DIV cycles before next FETCH_CTRL.
- cs low total = 34*CLK_DIV cycles per entry (136 at default).
- Empty list: start -> FETCH_CTRL -> FINISH; done pulses at T+3, busy falls same cycle as done pulse end (busy=0 at T+4).
- done pulses exactly once per run; start coincident with done is ignored.

## Test plan
- Reset then idle 100 cycles -> both cs=1, mclk=0, mdi=0, busy=0, done never pulses, config_read_addr=0.
- Entry 0 = {0x80,0x12,0xA5}, entry 1 ctrl=0x00; start -> one DAC frame shifting 0x12A5, 16 mclk rises, cs low 136 cycles, ADC lines static, done once, entry_count=1.
- Entry 0 = {0xE0,0x05,0x00}; ADC model drives 0x3C on mdo -> ADC frame 0x8500, readback_valid once with addr 0x05, data 0x3C.
- ctrl at address 0 = 0x00; start -> no cs activity, done at T+3, entry_count=0.
- All 64 entries valid writes alternating DAC/ADC -> 64 frames, address ends at 0xFE, entry_count=64, no wrap to entry 0; start pulses during run ignored.
- Assert reset at SHIFT bit 9 -> cs=1, mclk=0 asynchronously; after release, start replays from entry 0 with full frames.
